// File: rtl/gan_pkg.sv
// gan_pkg
//   Shared definitions for the GAN job sequencer slice.
//   - FSM state encoding (IDLE, RUN, HOLD) as plain 2-bit localparams
//   - N_INPUT: number of latent inputs carried per job
//   - Default geometry: DEF_N_PIX, DEF_N_LAYER, DEF_STAGE_L
//   - cnt_width(): counter width for a modulus, never less than 1 bit
package gan_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam int N_INPUT     = 2;
    localparam int DEF_N_PIX   = 9;
    localparam int DEF_N_LAYER = 4;
    localparam int DEF_STAGE_L = 5;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gan_stage_counter.sv
// gan_stage_counter
//   Nested stage/layer counter. The stage counter runs 0..STAGE_L-1 and the
//   layer counter advances each time the stage counter wraps. At the final
//   terminal count (last stage of last layer) both counters hold, so neither
//   ever exceeds its terminal value.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   clr         : synchronous clear of both counters (wins over en)
//   en          : advance by one stage
//   stage_last  : stage counter is at STAGE_L-1
//   layer_last  : layer counter is at N_LAYER-1
//   layer_cnt   : current layer
module gan_stage_counter
    import gan_pkg::*;
#(
    parameter int N_LAYER = DEF_N_LAYER,
    parameter int STAGE_L = DEF_STAGE_L,
    parameter int LW      = cnt_width(N_LAYER)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic          stage_last,
    output logic          layer_last,
    output logic [LW-1:0] layer_cnt
);

    localparam int SW = cnt_width(STAGE_L);
    localparam logic [SW-1:0] STAGE_MAX = SW'(STAGE_L - 1);
    localparam logic [LW-1:0] LAYER_MAX = LW'(N_LAYER - 1);

    logic [SW-1:0] stage_cnt;

    assign stage_last = (stage_cnt == STAGE_MAX);
    assign layer_last = (layer_cnt == LAYER_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            stage_cnt <= '0;
            layer_cnt <= '0;
        end else if (en && !(stage_last && layer_last)) begin
            if (stage_last) begin
                stage_cnt <= '0;
                layer_cnt <= layer_cnt + 1'b1;
            end else begin
                stage_cnt <= stage_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gan_job_sequencer.sv
// gan_job_sequencer
//   Job-level sequencer for the generator -> discriminator chain. Accepts one
//   job (two latent inputs and a bank choice), presents the registered inputs
//   and bank selects to the datapath for N_LAYER*STAGE_L cycles, then captures
//   disc_y and holds it until the consumer takes it.
//
//   Handshake: a transfer happens on every clock edge where valid && ready,
//   on both the input (in_valid/in_ready) and output (out_valid/out_ready)
//   side. Offered data is sampled only on the transfer edge. in_ready is
//   combinational: high in IDLE, or in HOLD while out_ready is high, which lets
//   a new job start on the same edge the previous result leaves.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : job handshake; in_1, in_2 latent inputs, in_choice
//                         bit0 weight bank, bit1 bias bank
//   a_1, a_2            : registered latent inputs to the generator
//   w_sel, b_sel        : per-layer weight/bias bank selects
//   disc_y              : discriminator output from the datapath
//   out_valid/out_ready : result handshake; out_y captured score
//   busy                : FSM in RUN
//   layer_idx           : layer in flight (0 in IDLE, N_LAYER-1 in HOLD)
//   gen_finish          : generator results valid for the current job
//   disc_finish         : same as out_valid
//   state_dbg           : raw FSM state (IDLE/RUN/HOLD encoding from gan_pkg)
//   gen_pix, pix_out    : only with GAN_PIXEL_CAPTURE_EN defined; pix_out
//                         samples gen_pix on the edge gen_finish rises
module gan_job_sequencer
    import gan_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int N_LAYER    = DEF_N_LAYER,
    parameter int GEN_LAYERS = 2,
    parameter int STAGE_L    = DEF_STAGE_L,
    parameter int N_PIX      = DEF_N_PIX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_1,
    input  logic [WIDTH-1:0]             in_2,
    input  logic [1:0]                   in_choice,
    output logic [WIDTH-1:0]             a_1,
    output logic [WIDTH-1:0]             a_2,
    output logic [N_LAYER-1:0]           w_sel,
    output logic [N_LAYER-1:0]           b_sel,
    input  logic [WIDTH-1:0]             disc_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_y,
    output logic                         busy,
    output logic [$clog2(N_LAYER)-1:0]   layer_idx,
    output logic                         gen_finish,
    output logic                         disc_finish,
    output logic [1:0]                   state_dbg
`ifdef GAN_PIXEL_CAPTURE_EN
    ,
    input  logic [N_PIX*WIDTH-1:0]       gen_pix,
    output logic [N_PIX*WIDTH-1:0]       pix_out
`endif
);

    localparam int LW = $clog2(N_LAYER);
    // Layer index just before the first discriminator layer; its last stage
    // is the point where the generator output becomes complete.
    localparam logic [LW-1:0] GEN_PRE = LW'(GEN_LAYERS - 1);

    if (GEN_LAYERS < 1 || GEN_LAYERS >= N_LAYER || STAGE_L < 1 || N_PIX < 1)
    begin : g_param_check
        $error("gan_job_sequencer: illegal parameter combination");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_acc;
    logic             out_acc;
    logic             done;
    logic             gen_set;
    logic             stage_last;
    logic             layer_last;
    logic [LW-1:0]    layer_cnt;

    logic [WIDTH-1:0]   a_q [N_INPUT];
    logic [N_LAYER-1:0] w_sel_q;
    logic [N_LAYER-1:0] b_sel_q;
    logic [WIDTH-1:0]   out_y_q;
    logic               gen_q;

    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = (state == HOLD) && out_ready;
    assign done     = (state == RUN) && stage_last && layer_last;
    assign gen_set  = (state == RUN) && stage_last && (layer_cnt == GEN_PRE);

    gan_stage_counter #(
        .N_LAYER (N_LAYER),
        .STAGE_L (STAGE_L),
        .LW      (LW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        // Clearing on any output accept returns layer_idx to 0 in IDLE and
        // restarts the schedule for a back-to-back job.
        .clr        (in_acc || out_acc),
        .en         ((state == RUN) && !done),
        .stage_last (stage_last),
        .layer_last (layer_last),
        .layer_cnt  (layer_cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_acc) state_nxt = RUN;
            RUN:  if (done) state_nxt = HOLD;
            HOLD: if (out_acc) state_nxt = in_acc ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q[0]  <= '0;
            a_q[1]  <= '0;
            w_sel_q <= '0;
            b_sel_q <= '0;
            out_y_q <= '0;
            gen_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_acc) begin
                a_q[0]  <= in_1;
                a_q[1]  <= in_2;
                w_sel_q <= {N_LAYER{in_choice[0]}};
                b_sel_q <= {N_LAYER{in_choice[1]}};
            end
            if (done) begin
                out_y_q <= disc_y;
            end
            // gen_set only occurs in RUN, so it never collides with a clear.
            if (in_acc || out_acc) begin
                gen_q <= 1'b0;
            end else if (gen_set) begin
                gen_q <= 1'b1;
            end
        end
    end

`ifdef GAN_PIXEL_CAPTURE_EN
    logic [N_PIX*WIDTH-1:0] pix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
        end else if (gen_set) begin
            pix_q <= gen_pix;
        end
    end

    assign pix_out = pix_q;
`endif

    assign a_1         = a_q[0];
    assign a_2         = a_q[1];
    assign w_sel       = w_sel_q;
    assign b_sel       = b_sel_q;
    assign out_y       = out_y_q;
    assign out_valid   = (state == HOLD);
    assign disc_finish = (state == HOLD);
    assign busy        = (state == RUN);
    assign layer_idx   = layer_cnt;
    assign gen_finish  = gen_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_gan_job_sequencer.sv
// tb_gan_job_sequencer
//   Bench for gan_job_sequencer: default-parameter instance plus a second
//   instance with N_LAYER=6, GEN_LAYERS=3, STAGE_L=2. Builds with or without
//   GAN_PIXEL_CAPTURE_EN.
module tb_gan_job_sequencer;
    import gan_pkg::*;

    localparam int W   = 32;
    localparam int NL  = 4;
    localparam int GL  = 2;
    localparam int SL  = 5;
    localparam int NP  = 9;
    localparam int LAT = NL * SL;
    localparam int NL2 = 6;
    localparam int GL2 = 3;
    localparam int SL2 = 2;
    localparam int LAT2 = NL2 * SL2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (defaults) ----------------
    logic          in_valid, in_ready, out_valid, out_ready, busy, gen_finish, disc_finish;
    logic [W-1:0]  in_1, in_2, a_1, a_2, disc_y, out_y;
    logic [1:0]    in_choice, state_dbg;
    logic [NL-1:0] w_sel, b_sel;
    logic [1:0]    layer_idx;
`ifdef GAN_PIXEL_CAPTURE_EN
    logic [NP*W-1:0] gen_pix, pix_out;
`endif

    gan_job_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_1(in_1), .in_2(in_2), .in_choice(in_choice),
        .a_1(a_1), .a_2(a_2), .w_sel(w_sel), .b_sel(b_sel),
        .disc_y(disc_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .busy(busy), .layer_idx(layer_idx), .gen_finish(gen_finish),
        .disc_finish(disc_finish), .state_dbg(state_dbg)
`ifdef GAN_PIXEL_CAPTURE_EN
        , .gen_pix(gen_pix), .pix_out(pix_out)
`endif
    );

    // ---------------- DUT 2 (parameter sweep) ----------------
    logic           p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_busy, p_gen_finish, p_disc_finish;
    logic [W-1:0]   p_in_1, p_in_2, p_a_1, p_a_2, p_disc_y, p_out_y;
    logic [1:0]     p_in_choice, p_state_dbg;
    logic [NL2-1:0] p_w_sel, p_b_sel;
    logic [2:0]     p_layer_idx;
`ifdef GAN_PIXEL_CAPTURE_EN
    logic [NP*W-1:0] p_gen_pix, p_pix_out;
`endif

    gan_job_sequencer #(.WIDTH(W), .N_LAYER(NL2), .GEN_LAYERS(GL2), .STAGE_L(SL2), .N_PIX(NP)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_1(p_in_1), .in_2(p_in_2), .in_choice(p_in_choice),
        .a_1(p_a_1), .a_2(p_a_2), .w_sel(p_w_sel), .b_sel(p_b_sel),
        .disc_y(p_disc_y),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_y(p_out_y),
        .busy(p_busy), .layer_idx(p_layer_idx), .gen_finish(p_gen_finish),
        .disc_finish(p_disc_finish), .state_dbg(p_state_dbg)
`ifdef GAN_PIXEL_CAPTURE_EN
        , .gen_pix(p_gen_pix), .pix_out(p_pix_out)
`endif
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // ---------------- driver tasks ----------------
    typedef struct {
        logic [W-1:0]  v1;
        logic [W-1:0]  v2;
        logic [1:0]    ch;
        logic [W-1:0]  dy;
        logic [NL-1:0] exp_w;
        logic [NL-1:0] exp_b;
    } job_vec_t;

    job_vec_t jobs [4];

    // Offers job j; caller guarantees it will be accepted on the next edge
    // (IDLE, or HOLD with out_ready high). Walks the whole schedule to HOLD.
    task automatic run_job(input job_vec_t j);
        in_valid  = 1'b1;
        in_1      = j.v1;
        in_2      = j.v2;
        in_choice = j.ch;
        #1;
        chk("accept_in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid  = 1'b0;
        in_1      = $urandom;
        in_2      = $urandom;
        in_choice = 2'($urandom_range(0, 3));
        out_ready = 1'b0;
        chk("e0_busy", 64'(busy), 64'(1));
        chk("e0_out_valid", 64'(out_valid), 64'(0));
        chk("e0_layer_idx", 64'(layer_idx), 64'(0));
        chk("e0_gen_finish", 64'(gen_finish), 64'(0));
        chk("e0_a_1", 64'(a_1), 64'(j.v1));
        chk("e0_a_2", 64'(a_2), 64'(j.v2));
        for (int e = 1; e <= LAT; e++) begin
            disc_y = (e == LAT) ? j.dy : (j.dy ^ ($urandom | 32'h1));
            tick();
            chk("run_gen_finish", 64'(gen_finish), 64'(e >= GL * SL));
            chk("run_layer_idx", 64'(layer_idx), 64'((e < LAT) ? e / SL : NL - 1));
            chk("run_out_valid", 64'(out_valid), 64'(e == LAT));
            chk("run_disc_finish", 64'(disc_finish), 64'(e == LAT));
            chk("run_busy", 64'(busy), 64'(e < LAT));
            chk("run_w_sel", 64'(w_sel), 64'(j.exp_w));
            chk("run_b_sel", 64'(b_sel), 64'(j.exp_b));
        end
        chk("hold_out_y", 64'(out_y), 64'(j.dy));
        chk("hold_in_ready", 64'(in_ready), 64'(0));
        disc_y = $urandom;
    endtask

    // ---------------- stimulus ----------------
    logic [NP*W-1:0] pix_exp;
    bit              m_active;
    int              m_a;
    logic [W-1:0]    m_v1;
    logic [NL-1:0]   m_w, m_b;
    bit              m_hold, m_rdy, m_acc;
    int              m_layer;
    int              n_results;

    initial begin
        jobs[0] = '{v1: 32'd3, v2: 32'hFFFF_FFFE, ch: 2'b01, dy: 32'h0000_1234, exp_w: 4'b1111, exp_b: 4'b0000};
        jobs[1] = '{v1: 32'h7FFF_FFFF, v2: 32'h8000_0000, ch: 2'b10, dy: 32'hDEAD_BEEF, exp_w: 4'b0000, exp_b: 4'b1111};
        jobs[2] = '{v1: 32'h0000_00A5, v2: 32'h0000_005A, ch: 2'b11, dy: 32'h0BAD_F00D, exp_w: 4'b1111, exp_b: 4'b1111};
        jobs[3] = '{v1: 32'h1234_5678, v2: 32'h0, ch: 2'b00, dy: 32'hFFFF_FFFF, exp_w: 4'b0000, exp_b: 4'b0000};

        rst = 1'b1;
        in_valid = 1'b0; in_1 = '0; in_2 = '0; in_choice = '0; disc_y = '0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_in_1 = '0; p_in_2 = '0; p_in_choice = '0; p_disc_y = '0; p_out_ready = 1'b0;
`ifdef GAN_PIXEL_CAPTURE_EN
        gen_pix = '0; p_gen_pix = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_y", 64'(out_y), 64'(0));
        chk("rst_gen_finish", 64'(gen_finish), 64'(0));
        chk("rst_layer_idx", 64'(layer_idx), 64'(0));
        chk("rst_a_1", 64'(a_1), 64'(0));
        chk("rst_w_sel", 64'(w_sel), 64'(0));
        chk("rst_state", 64'(state_dbg), 64'(IDLE));

        // Single job from the table, then backpressure for 7 cycles
        run_job(jobs[0]);
        in_valid = 1'b1; in_1 = 32'h5555_5555; in_2 = 32'h6666_6666; in_choice = 2'b10;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("bp_out_y", 64'(out_y), 64'(jobs[0].dy));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_a_1", 64'(a_1), 64'(jobs[0].v1));
            chk("bp_layer_idx", 64'(layer_idx), 64'(NL - 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'(0));
        chk("drain_busy", 64'(busy), 64'(0));
        chk("drain_gen_finish", 64'(gen_finish), 64'(0));
        chk("drain_layer_idx", 64'(layer_idx), 64'(0));
        chk("drain_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b0;

        // Back-to-back: job 2 accepted on the same edge job 1 leaves
        run_job(jobs[1]);
        out_ready = 1'b1;
        run_job(jobs[2]);
        out_ready = 1'b1;
        tick();
        chk("b2b_idle_out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b0;
        run_job(jobs[3]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during RUN aborts the job silently
        in_valid = 1'b1; in_1 = 32'h1111_2222; in_2 = 32'h3333_4444; in_choice = 2'b11;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("abort_pre_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_a_1", 64'(a_1), 64'(0));
        chk("abort_a_2", 64'(a_2), 64'(0));
        chk("abort_w_sel", 64'(w_sel), 64'(0));
        chk("abort_b_sel", 64'(b_sel), 64'(0));
        chk("abort_out_y", 64'(out_y), 64'(0));
        chk("abort_layer_idx", 64'(layer_idx), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("abort_no_valid", 64'(out_valid), 64'(0));
        end
        out_ready = 1'b0;

        // Randomized traffic against a timestamp-based reference model:
        // a job accepted at edge a is in RUN for edges a..a+LAT-1, in HOLD
        // from a+LAT, and its result is disc_y as driven just before a+LAT.
        m_active = 0; m_a = 0; n_results = 0;
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_1      = $urandom;
            in_2      = $urandom;
            in_choice = 2'($urandom_range(0, 3));
            disc_y    = $urandom;
            #1;
            m_hold = m_active && (edge_n >= m_a + LAT);
            m_rdy  = !m_active || (m_hold && out_ready);
            chk("rnd_in_ready", 64'(in_ready), 64'(m_rdy));
            if (m_hold && exp_q.size() > 0)
                chk("rnd_out_y", 64'(out_y), 64'(exp_q[0]));
            if (m_active && (edge_n + 1 == m_a + LAT))
                exp_q.push_back(disc_y);
            m_acc = in_valid && m_rdy;
            if (m_hold && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_active = 0;
                n_results++;
            end
            if (m_acc) begin
                m_active = 1;
                m_a  = edge_n + 1;
                m_v1 = in_1;
                m_w  = {NL{in_choice[0]}};
                m_b  = {NL{in_choice[1]}};
            end
            tick();
            m_layer = m_active ? (edge_n - m_a) / SL : 0;
            if (m_layer > NL - 1) m_layer = NL - 1;
            chk("rnd_out_valid", 64'(out_valid), 64'(m_active && (edge_n >= m_a + LAT)));
            chk("rnd_busy", 64'(busy), 64'(m_active && (edge_n < m_a + LAT)));
            chk("rnd_gen_finish", 64'(gen_finish), 64'(m_active && (edge_n >= m_a + GL * SL)));
            chk("rnd_layer_idx", 64'(layer_idx), 64'(m_layer));
            if (m_active) begin
                chk("rnd_a_1", 64'(a_1), 64'(m_v1));
                chk("rnd_w_sel", 64'(w_sel), 64'(m_w));
                chk("rnd_b_sel", 64'(b_sel), 64'(m_b));
            end
        end
        chk("rnd_some_results", 64'(n_results > 5), 64'(1));
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 2) tick();
        chk("rnd_final_idle", 64'(state_dbg), 64'(IDLE));
        out_ready = 1'b0;

        // Parameter sweep instance: latency 12, gen_finish at edge 6
        p_in_valid = 1'b1; p_in_1 = 32'h0000_0042; p_in_2 = 32'h0000_0017; p_in_choice = 2'b10;
        pix_exp = '0;
        tick();
        p_in_valid = 1'b0;
        chk("p_e0_busy", 64'(p_busy), 64'(1));
        chk("p_e0_b_sel", 64'(p_b_sel), 64'(6'b111111));
        chk("p_e0_w_sel", 64'(p_w_sel), 64'(0));
        for (int e = 1; e <= LAT2; e++) begin
`ifdef GAN_PIXEL_CAPTURE_EN
            for (int k = 0; k < NP; k++) p_gen_pix[k*W +: W] = $urandom;
            if (e == GL2 * SL2) pix_exp = p_gen_pix;
`endif
            p_disc_y = (e == LAT2) ? 32'hABCD_0123 : 32'h0000_0F0F + 32'(e);
            tick();
            chk("p_gen_finish", 64'(p_gen_finish), 64'(e >= GL2 * SL2));
            chk("p_out_valid", 64'(p_out_valid), 64'(e == LAT2));
            chk("p_layer_idx", 64'(p_layer_idx), 64'((e / SL2 > NL2 - 1) ? NL2 - 1 : e / SL2));
        end
        chk("p_out_y", 64'(p_out_y), 64'(32'hABCD_0123));
`ifdef GAN_PIXEL_CAPTURE_EN
        n_checks++;
        if (p_pix_out !== pix_exp) begin
            n_fail++;
            $display("FAIL p_pix_out: got %0h expected %0h", p_pix_out, pix_exp);
        end
`endif
        p_out_ready = 1'b1;
        tick();
        chk("p_drain_out_valid", 64'(p_out_valid), 64'(0));
        p_out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gan_job_sequencer.md
Name: gan_job_sequencer

Overview:
- Job-level sequencer for the generator→discriminator inference chain. Replaces the free-running counter and choice shift-register with a start/accept handshake, a parametrised layer/stage counter and result capture.
- Accepts one job: two latent inputs plus a bank choice. It drives the registered inputs and the memory bank selects to the datapath for a fixed schedule, then captures the discriminator score and holds it until the consumer accepts it.
- Sits between the host interface and the generator/discriminator instances.

Parameters:
- WIDTH, 32, data word width (signed fixed-point).
- N_LAYER, 4, total pipelined layers (generator plus discriminator).
- GEN_LAYERS, 2, number of leading layers belonging to the generator; must satisfy 1 ≤ GEN_LAYERS < N_LAYER.
- STAGE_L, 5, cycles of datapath latency per layer.
- N_PIX, 9, generator output pixel count (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  job offered
- in_ready  out  1  job can be accepted
- in_1  in  WIDTH  latent input 1
- in_2  in  WIDTH  latent input 2
- in_choice  in  2  bank select: bit0 = weight bank, bit1 = bias bank
- a_1  out  WIDTH  registered in_1 to the generator
- a_2  out  WIDTH  registered in_2 to the generator
- w_sel  out  N_LAYER  per-layer weight bank select
- b_sel  out  N_LAYER  per-layer bias bank select
- disc_y  in  WIDTH  discriminator output from the datapath
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  captured discriminator score
- busy  out  1  state is RUN
- layer_idx  out  $clog2(N_LAYER)  layer currently in flight
- gen_finish  out  1  generator results valid for the current job
- disc_finish  out  1  equals out_valid

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
  - Reset forces state IDLE and clears every register: a_1, a_2, w_sel, b_sel, out_y, counters.
  - After reset, out_valid=0, busy=0, gen_finish=0, in_ready=1 (combinational from state).
  - Reset mid-RUN or mid-HOLD aborts the job silently; no output is produced.
- Handshake: a transfer occurs on any edge where valid && ready. Offered data need not be held stable before acceptance.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- On input accept:
  - a_1←in_1, a_2←in_2.
  - w_sel←{N_LAYER{in_choice[0]}}, b_sel←{N_LAYER{in_choice[1]}}.
  - stage_cnt←0, layer_cnt←0, state←RUN.
  - All of these hold constant for the whole job.
- States:
  - IDLE: waits for an input accept, then goes to RUN.
  - RUN: stage_cnt increments each cycle and wraps STAGE_L-1→0. layer_cnt increments on each wrap.
    - At stage_cnt==STAGE_L-1 && layer_cnt==N_LAYER-1: out_y←disc_y, state←HOLD.
    - RUN therefore lasts exactly N_LAYER*STAGE_L cycles.
  - HOLD: out_valid=1 and out_y is stable.
    - Output accept without a simultaneous input accept: go to IDLE.
    - Output and input accepted on the same edge: go directly to RUN with the new job (back-to-back, no bubble).
    - out_ready low: remain in HOLD indefinitely.
- Latency: input accepted at edge k gives out_valid high from edge k+N_LAYER*STAGE_L (20 cycles at defaults).
- gen_finish:
  - Goes high on the edge where layer_cnt becomes GEN_LAYERS (stage_cnt 0).
  - Stays high through the rest of RUN and HOLD.
  - Clears on the next input accept, and in IDLE.
- layer_idx = layer_cnt. It reads 0 in IDLE and N_LAYER-1 in HOLD.
- Inputs are ignored while in_ready=0; no queueing is performed.
- Counters never exceed their terminal values. No arithmetic is performed on data.

Optional Feature:
- Macro GAN_PIXEL_CAPTURE_EN.
- Defined:
  - Adds input gen_pix (N_PIX*WIDTH) and output pix_out (N_PIX*WIDTH).
  - pix_out←gen_pix on the edge gen_finish rises, held until the next gen_finish rise; reset 0.
- Undefined: neither port exists and no capture registers are built.

Decomposition:
- Shared package gan_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - N_INPUT=2 and the default N_PIX, N_LAYER and STAGE_L values.
- One sub-module, gan_stage_counter: nested stage/layer counter with enable, clear and terminal-count outputs.
- Input and result registers reuse the existing register utility.

Test Plan:
- Reset, then idle 5 cycles → in_ready=1, out_valid=0, busy=0, out_y=0.
- Single job: in_1=3, in_2=-2, in_choice=2'b01 at edge 0; disc_y driven 32'h0000_1234 on cycle 19 →
  - w_sel=4'b1111, b_sel=0 during RUN;
  - gen_finish rises at edge 10;
  - out_valid at edge 20 with out_y=32'h0000_1234.
- Backpressure: out_ready=0 for 7 cycles after out_valid → out_y stable and in_ready=0; the job offered meanwhile is not accepted.
- Back-to-back: out_ready=1 and in_valid=1 in the same HOLD cycle → next edge busy=1, layer_idx=0, out_valid=0; second result at +20 cycles.
- Reset asserted at RUN cycle 8 → next edge IDLE, all outputs 0, no out_valid ever issued for the aborted job.
- Parameter sweep N_LAYER=6, GEN_LAYERS=3, STAGE_L=2 → latency 12, gen_finish rises at edge 6. With GAN_PIXEL_CAPTURE_EN, pix_out equals gen_pix sampled at edge 6.
